// File: rtl/timestamp_sync_pkg.sv
// Shared types and constants for the timestamp-injection scheduler and injectors.
package timestamp_sync_pkg;

    typedef enum logic [1:0] {
        DISABLED = 2'd0,
        IDLE     = 2'd1,
        GRANT    = 2'd2,
        HOLDOFF  = 2'd3
    } sched_state_e;

    localparam int unsigned TICK_W_DEF = 64;
    localparam int unsigned SYNC_W_DEF = 32;

    localparam logic [31:0] EMPTY_TIMESTAMP = 32'hDEADBEEF;

endpackage

// File: rtl/timestamp_sync_sched_rr_arbiter.sv
// N-way round-robin pick: first set request at or after the pointer, cyclic.
module rr_arbiter #(
    parameter int unsigned N     = 4,
    parameter int unsigned IDX_W = 2
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [N-1:0]     grant_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             valid_o
);

    int unsigned j;

    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        j       = 0;
        for (int unsigned i = 0; i < N; i++) begin
            j = (int'(ptr_i) + i) % N;
            if (!valid_o && req_i[j]) begin
                valid_o    = 1'b1;
                grant_o[j] = 1'b1;
                idx_o      = IDX_W'(j);
            end
        end
    end

endmodule

// File: rtl/timestamp_sync_sched.sv
// Central timestamp scheduler: tick/sync counters plus round-robin grant of sync requests.
// Optional statistics counters are built when TS_SCHED_STATS_EN is defined.
module timestamp_sync_sched
    import timestamp_sync_pkg::*;
#(
    parameter int unsigned NUM_AXI_STREAM = 1,
    parameter int unsigned TICK_W         = TICK_W_DEF,
    parameter int unsigned SYNC_W         = SYNC_W_DEF,
    parameter int unsigned HOLDOFF_W      = 16
) (
    input  logic                      axis_aclk,
    input  logic                      axil_aresetn,
    input  logic                      i_enable,
    input  logic [15:0]               i_tick_inc,
    input  logic                      i_tick_load,
    input  logic [TICK_W-1:0]         i_tick_load_val,
    input  logic [HOLDOFF_W-1:0]      i_holdoff,
    input  logic [NUM_AXI_STREAM-1:0] i_sync_req,
    output logic [TICK_W-1:0]         o_curr_tick,
    output logic [SYNC_W-1:0]         o_nb_sync,
    output logic [TICK_W-1:0]         o_tick_snap,
    output logic [NUM_AXI_STREAM-1:0] o_grant,
    output logic                      o_grant_valid,
    output logic [NUM_AXI_STREAM-1:0] o_pending,
`ifdef TS_SCHED_STATS_EN
    output logic [31:0]               o_merge_cnt,
    output logic [31:0]               o_grant_cnt,
`endif
    output logic                      o_busy
);

    localparam int unsigned IDX_W = (NUM_AXI_STREAM > 1) ? $clog2(NUM_AXI_STREAM) : 1;

    sched_state_e                state_q, state_d;
    logic [TICK_W-1:0]           curr_tick_q, curr_tick_d;
    logic [SYNC_W-1:0]           nb_sync_q, nb_sync_d;
    logic [TICK_W-1:0]           tick_snap_q, tick_snap_d;
    logic [NUM_AXI_STREAM-1:0]   grant_q, grant_d;
    logic                        grant_valid_q, grant_valid_d;
    logic [NUM_AXI_STREAM-1:0]   pending_q, pending_d;
    logic                        busy_q, busy_d;
    logic [IDX_W-1:0]            rr_ptr_q, rr_ptr_d;
    logic [HOLDOFF_W-1:0]        hold_cnt_q, hold_cnt_d;

    logic [NUM_AXI_STREAM-1:0]   arb_grant;
    logic [IDX_W-1:0]            arb_idx;
    logic                        arb_valid;
    logic                        take_grant;
    logic                        flush;
    logic [NUM_AXI_STREAM-1:0]   pending_set;
    logic [NUM_AXI_STREAM-1:0]   pending_clr;

    rr_arbiter #(
        .N     (NUM_AXI_STREAM),
        .IDX_W (IDX_W)
    ) u_rr_arbiter (
        .req_i   (pending_q),
        .ptr_i   (rr_ptr_q),
        .grant_o (arb_grant),
        .idx_o   (arb_idx),
        .valid_o (arb_valid)
    );

    always_comb begin
        state_d       = state_q;
        nb_sync_d     = nb_sync_q;
        tick_snap_d   = tick_snap_q;
        grant_d       = '0;
        grant_valid_d = 1'b0;
        rr_ptr_d      = rr_ptr_q;
        hold_cnt_d    = hold_cnt_q;
        take_grant    = 1'b0;
        flush         = 1'b0;
        pending_set   = (state_q != DISABLED) ? i_sync_req : '0;
        pending_clr   = '0;

        curr_tick_d = i_tick_load ? i_tick_load_val : curr_tick_q + TICK_W'(i_tick_inc);

        unique case (state_q)
            DISABLED: begin
                if (i_enable) state_d = IDLE;
            end
            IDLE: begin
                if (!i_enable) begin
                    state_d = DISABLED;
                    flush   = 1'b1;
                end else if (arb_valid) begin
                    take_grant = 1'b1;
                end
            end
            GRANT: begin
                hold_cnt_d = i_holdoff;
                state_d    = (i_holdoff != '0) ? HOLDOFF : IDLE;
            end
            HOLDOFF: begin
                // The last holdoff cycle hands straight to GRANT so spacing is holdoff+1.
                if (!i_enable) begin
                    state_d    = DISABLED;
                    flush      = 1'b1;
                    hold_cnt_d = '0;
                end else if (hold_cnt_q <= HOLDOFF_W'(1)) begin
                    hold_cnt_d = '0;
                    if (arb_valid) take_grant = 1'b1;
                    else           state_d    = IDLE;
                end else begin
                    hold_cnt_d = hold_cnt_q - HOLDOFF_W'(1);
                end
            end
            default: state_d = DISABLED;
        endcase

        if (take_grant) begin
            state_d       = GRANT;
            grant_d       = arb_grant;
            grant_valid_d = 1'b1;
            nb_sync_d     = nb_sync_q + SYNC_W'(1);
            tick_snap_d   = curr_tick_q;
            pending_clr   = arb_grant;
            rr_ptr_d      = (arb_idx == IDX_W'(NUM_AXI_STREAM - 1)) ? '0 : arb_idx + IDX_W'(1);
        end

        pending_d = flush ? '0 : ((pending_q & ~pending_clr) | pending_set);
        busy_d    = (state_d == GRANT) || (state_d == HOLDOFF);
    end

    always_ff @(posedge axis_aclk) begin
        if (!axil_aresetn) begin
            state_q       <= DISABLED;
            curr_tick_q   <= '0;
            nb_sync_q     <= '0;
            tick_snap_q   <= '0;
            grant_q       <= '0;
            grant_valid_q <= 1'b0;
            pending_q     <= '0;
            busy_q        <= 1'b0;
            rr_ptr_q      <= '0;
            hold_cnt_q    <= '0;
        end else begin
            state_q       <= state_d;
            curr_tick_q   <= curr_tick_d;
            nb_sync_q     <= nb_sync_d;
            tick_snap_q   <= tick_snap_d;
            grant_q       <= grant_d;
            grant_valid_q <= grant_valid_d;
            pending_q     <= pending_d;
            busy_q        <= busy_d;
            rr_ptr_q      <= rr_ptr_d;
            hold_cnt_q    <= hold_cnt_d;
        end
    end

    assign o_curr_tick   = curr_tick_q;
    assign o_nb_sync     = nb_sync_q;
    assign o_tick_snap   = tick_snap_q;
    assign o_grant       = grant_q;
    assign o_grant_valid = grant_valid_q;
    assign o_pending     = pending_q;
    assign o_busy        = busy_q;

`ifdef TS_SCHED_STATS_EN
    logic [31:0]               merge_cnt_q, merge_cnt_d;
    logic [31:0]               grant_cnt_q, grant_cnt_d;
    logic [NUM_AXI_STREAM-1:0] merge_hits;
    logic [31:0]               merge_pop;
    logic [32:0]               merge_sum;

    always_comb begin
        merge_hits = pending_set & pending_q;
        merge_pop  = '0;
        for (int unsigned i = 0; i < NUM_AXI_STREAM; i++) begin
            merge_pop = merge_pop + 32'(merge_hits[i]);
        end
        merge_sum   = {1'b0, merge_cnt_q} + {1'b0, merge_pop};
        merge_cnt_d = merge_sum[32] ? '1 : merge_sum[31:0];
        grant_cnt_d = grant_cnt_q;
        if (take_grant && (grant_cnt_q != '1)) grant_cnt_d = grant_cnt_q + 32'd1;
    end

    always_ff @(posedge axis_aclk) begin
        if (!axil_aresetn) begin
            merge_cnt_q <= '0;
            grant_cnt_q <= '0;
        end else begin
            merge_cnt_q <= merge_cnt_d;
            grant_cnt_q <= grant_cnt_d;
        end
    end

    assign o_merge_cnt = merge_cnt_q;
    assign o_grant_cnt = grant_cnt_q;
`endif

endmodule

// File: tb/tb_timestamp_sync_sched.sv
// Directed self-checking bench for timestamp_sync_sched with four streams.
module tb_timestamp_sync_sched;

    localparam int unsigned N = 4;

    logic          clk = 1'b0;
    logic          rstn;
    logic          enable;
    logic [15:0]   tick_inc;
    logic          tick_load;
    logic [63:0]   tick_load_val;
    logic [15:0]   holdoff;
    logic [N-1:0]  sync_req;
    logic [63:0]   curr_tick;
    logic [31:0]   nb_sync;
    logic [63:0]   tick_snap;
    logic [N-1:0]  grant;
    logic          grant_valid;
    logic [N-1:0]  pending;
    logic          busy;
`ifdef TS_SCHED_STATS_EN
    logic [31:0]   merge_cnt;
    logic [31:0]   grant_cnt;
`endif

    int unsigned checks = 0;
    int unsigned errors = 0;

    always #5 clk = ~clk;

    timestamp_sync_sched #(
        .NUM_AXI_STREAM (N),
        .TICK_W         (64),
        .SYNC_W         (32),
        .HOLDOFF_W      (16)
    ) dut (
        .axis_aclk       (clk),
        .axil_aresetn    (rstn),
        .i_enable        (enable),
        .i_tick_inc      (tick_inc),
        .i_tick_load     (tick_load),
        .i_tick_load_val (tick_load_val),
        .i_holdoff       (holdoff),
        .i_sync_req      (sync_req),
        .o_curr_tick     (curr_tick),
        .o_nb_sync       (nb_sync),
        .o_tick_snap     (tick_snap),
        .o_grant         (grant),
        .o_grant_valid   (grant_valid),
        .o_pending       (pending),
`ifdef TS_SCHED_STATS_EN
        .o_merge_cnt     (merge_cnt),
        .o_grant_cnt     (grant_cnt),
`endif
        .o_busy          (busy)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "timeout");
    end

    initial begin
        logic [63:0] prev_snap;
        int          g_first;
        int          g_second;
        int          g_count;
        logic        seen;

        rstn = 1'b0; enable = 1'b0; tick_inc = '0; tick_load = 1'b0;
        tick_load_val = '0; holdoff = '0; sync_req = '0;

        repeat (3) @(negedge clk);
        check("rst_tick", curr_tick, 64'd0);
        check("rst_nb_sync", nb_sync, 64'd0);
        check("rst_grant", {grant_valid, grant}, 64'd0);
        check("rst_pending", pending, 64'd0);
        check("rst_busy", busy, 64'd0);
        check("rst_snap", tick_snap, 64'd0);

        // Free-running tick with enable, no requests
        rstn = 1'b1; enable = 1'b1; tick_inc = 16'd1;
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            seen = seen | grant_valid;
        end
        check("tick_100", curr_tick, 64'd100);
        check("idle_nb_sync", nb_sync, 64'd0);
        check("idle_no_grant", seen, 64'd0);

        // Load near the top and wrap with inc=3
        tick_load = 1'b1; tick_load_val = 64'hFFFF_FFFF_FFFF_FFFE; tick_inc = 16'd3;
        @(negedge clk);
        tick_load = 1'b0;
        check("tick_load", curr_tick, 64'hFFFF_FFFF_FFFF_FFFE);
        @(negedge clk);
        check("tick_wrap1", curr_tick, 64'd1);
        @(negedge clk);
        check("tick_wrap4", curr_tick, 64'd4);

        // All four streams at once, holdoff 0
        holdoff = 16'd0; sync_req = 4'b1111;
        @(negedge clk);
        sync_req = '0;
        check("burst_pending", pending, 64'hF);
        prev_snap = '0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check($sformatf("burst_grant%0d", k), {grant_valid, grant}, {59'd0, 1'b1, 4'(1 << k)});
            check($sformatf("burst_nb%0d", k), nb_sync, 64'(k + 1));
            check($sformatf("burst_snap_inc%0d", k), 64'(tick_snap > prev_snap), 64'd1);
            check($sformatf("burst_busy%0d", k), busy, 64'd1);
            prev_snap = tick_snap;
            if (k < 3) begin
                @(negedge clk);
                check($sformatf("burst_gap%0d", k), grant_valid, 64'd0);
            end
        end
        @(negedge clk);
        check("burst_done_pending", pending, 64'd0);

        // Holdoff 10: stream 2 requested twice, 3 cycles apart
        holdoff = 16'd10;
        g_first = -1; g_second = -1; g_count = 0;
        for (int i = 0; i < 30; i++) begin
            if (grant_valid) begin
                g_count++;
                if (g_first < 0) g_first = i;
                else if (g_second < 0) g_second = i;
                check($sformatf("hold_grant_vec%0d", i), grant, 64'b0100);
            end
            sync_req = (i == 0 || i == 3) ? 4'b0100 : 4'b0000;
            @(negedge clk);
        end
        sync_req = '0;
        check("hold_first_latency", 64'(g_first), 64'd2);
        check("hold_spacing", 64'(g_second - g_first), 64'd11);
        check("hold_count", 64'(g_count), 64'd2);
        check("hold_nb_sync", nb_sync, 64'd6);
        for (int i = 0; i < 50 && busy; i++) @(negedge clk);
        check("hold_idle", busy, 64'd0);

        // Streams 1 and 3 pending, disable during holdoff
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (i == 2) begin
                check("dis_grant3", {grant_valid, grant}, 64'h18);
                check("dis_nb_sync", nb_sync, 64'd7);
            end
            if (i == 4) begin
                check("dis_pend_before", pending, 64'b0010);
                check("dis_busy_before", busy, 64'd1);
                enable = 1'b0;
            end
            if (i == 5) begin
                check("dis_pend_after", pending, 64'd0);
                check("dis_busy_after", busy, 64'd0);
            end
            if (i >= 5) seen = seen | grant_valid;
            sync_req = (i == 0) ? 4'b1010 : ((i >= 6 && i <= 8) ? 4'b0010 : 4'b0000);
            @(negedge clk);
        end
        sync_req = '0;
        check("dis_no_grant", seen, 64'd0);
        check("dis_pend_ignored", pending, 64'd0);

        enable = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            seen = seen | grant_valid;
        end
        check("reen_no_grant", seen, 64'd0);
        sync_req = 4'b0010;
        @(negedge clk);
        sync_req = '0;
        @(negedge clk);
        check("reen_grant1", {grant_valid, grant}, 64'h12);
        check("reen_nb_sync", nb_sync, 64'd8);

        // Reset while in holdoff with a fresh request arriving
        @(negedge clk);
        check("pre_rst_busy", busy, 64'd1);
        rstn = 1'b0; sync_req = 4'b0001;
        repeat (2) @(negedge clk);
        sync_req = '0;
        check("rst2_pending", pending, 64'd0);
        check("rst2_busy", busy, 64'd0);
        check("rst2_nb_sync", nb_sync, 64'd0);
        check("rst2_tick", curr_tick, 64'd0);
        check("rst2_grant", {grant_valid, grant}, 64'd0);

`ifdef TS_SCHED_STATS_EN
        check("stats_rst_merge", merge_cnt, 64'd0);
        check("stats_rst_grant", grant_cnt, 64'd0);
        rstn = 1'b1; enable = 1'b1; holdoff = 16'd20;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            sync_req = 4'b0001;
            @(negedge clk);
        end
        sync_req = '0;
        check("stats_merge", merge_cnt, 64'd3);
        check("stats_grant", grant_cnt, 64'd1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/timestamp_sync_sched.md
Name: timestamp_sync_sched

Overview:
- Central scheduler for the timestamp-injection datapath.
- Owns the 64-bit tick counter and the 32-bit sync sequence counter that feed every per-stream injector (i_curr_tick / i_nb_sync).
- Collects per-stream sync_detected pulses and arbitrates them round-robin: each granted stream gets a unique nb_sync value plus a tick snapshot.
- Enforces a configurable holdoff between grants.

Parameters:
NUM_AXI_STREAM, 1, number of injector streams / request lines
TICK_W, 64, tick counter width
SYNC_W, 32, sequence counter width
HOLDOFF_W, 16, width of holdoff configuration

Ports:
axis_aclk  in  1  single clock for all logic
axil_aresetn  in  1  synchronous active-low reset
i_enable  in  1  scheduler enable; low forces DISABLED
i_tick_inc  in  16  per-cycle tick increment
i_tick_load  in  1  one-cycle pulse: load tick counter
i_tick_load_val  in  TICK_W  value loaded on i_tick_load
i_holdoff  in  HOLDOFF_W  cycles spent in HOLDOFF after each grant
i_sync_req  in  NUM_AXI_STREAM  per-stream sync_detected pulses
o_curr_tick  out  TICK_W  free-running tick counter
o_nb_sync  out  SYNC_W  sequence number of the last grant
o_tick_snap  out  TICK_W  o_curr_tick value captured at the last grant
o_grant  out  NUM_AXI_STREAM  one-hot grant, one-cycle pulse
o_grant_valid  out  1  high in the cycle o_grant is nonzero
o_pending  out  NUM_AXI_STREAM  latched, not-yet-granted requests
o_busy  out  1  high in GRANT or HOLDOFF

Behaviour:
- Reset (axil_aresetn low at a clock edge): every output and register goes to 0, FSM goes to DISABLED, round-robin pointer goes to stream 0. Reset mid-holdoff abandons the holdoff and clears pending.
- Tick counter:
  - i_tick_load has priority: o_curr_tick <= i_tick_load_val on the next edge.
  - Otherwise it adds i_tick_inc (zero-extended) every cycle, independent of i_enable, and wraps modulo 2^TICK_W.
- Request latch:
  - pending[k] sets when i_sync_req[k]=1 and the FSM is not DISABLED.
  - pending[k] clears on grant to k.
  - A request in the same cycle as its own grant re-sets pending (set wins). A repeat request while already pending merges.
- FSM:
  - DISABLED: i_enable=1 -> IDLE. Requests are ignored.
  - IDLE: any pending -> GRANT. i_enable=0 -> DISABLED and pending is cleared.
  - GRANT (one cycle):
    - o_grant_valid=1 and o_grant=one-hot of the winner.
    - Winner = first pending index at or after the rr pointer, cyclic search.
    - The rr pointer moves to winner+1 (mod NUM_AXI_STREAM).
    - o_nb_sync increments by 1 (wraps modulo 2^SYNC_W).
    - o_tick_snap captures o_curr_tick as it stood before this edge.
    - Next state: HOLDOFF if i_holdoff>0, else IDLE.
  - HOLDOFF: a down-counter loaded with i_holdoff; leave to IDLE when it reaches 1→0. Requests still latch here. i_enable=0 -> DISABLED and pending is cleared.
- Timing:
  - Latency from i_sync_req to grant is 2 cycles minimum: latch, then IDLE→GRANT.
  - Grant spacing is i_holdoff+1 cycles when i_holdoff>0, otherwise 2 cycles.
- Simultaneous requests from several streams: the first grant is in cycle latch+1; later ones follow in rr order.
- First grant after reset yields o_nb_sync=1.
- i_holdoff is sampled only on entry to HOLDOFF.

Optional Feature:
- Macro: TS_SCHED_STATS_EN.
- With the macro defined, two extra outputs are added:
  - o_merge_cnt (32-bit): increments when i_sync_req[k] hits an already-set pending[k]. Multiple merges in one cycle add their popcount.
  - o_grant_cnt (32-bit): increments on each grant.
  - Both saturate at all-ones and reset to 0.
- Without the macro, neither port nor the logic exists.

Decomposition:
- Package timestamp_sync_pkg holds:
  - the FSM state enum (DISABLED, IDLE, GRANT, HOLDOFF);
  - the default TICK_W/SYNC_W constants;
  - the EMPTY_TIMESTAMP constant (32'hDEADBEEF), shared with the injectors.
- One sub-module, rr_arbiter: parameterised N-way round-robin pick of first set bit from pointer, returning a one-hot and an index.

Test Plan:
- Reset then i_enable=1, i_tick_inc=1, 100 cycles -> o_curr_tick=100 (±load timing), o_nb_sync=0, no grants.
- i_tick_load with 64'hFFFF_FFFF_FFFF_FFFE, inc=3 -> next values 64'h...FFFE, then 1, then 4 (wrap).
- NUM_AXI_STREAM=4, holdoff=0, i_sync_req=4'b1111 one cycle -> grants 0001, 0010, 0100, 1000 two cycles apart; o_nb_sync 1..4; o_tick_snap strictly increasing.
- holdoff=10, request stream 2 twice 3 cycles apart -> second grant exactly 11 cycles after the first.
- Pending on streams 1 and 3, drop i_enable during HOLDOFF -> DISABLED, o_pending=0, no further grants until re-enable.
- STATS_EN: repeat request on pending stream 0 three times -> o_merge_cnt=3, o_grant_cnt=1.
